// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA serial link receiver: FSM encoding and error codes.
package fpga_link_pkg;

  typedef enum logic [8:0] {
    ST_IDLE  = 9'h001,
    ST_START = 9'h002,
    ST_WAIT  = 9'h004,
    ST_SHIFT = 9'h008,
    ST_CHECK = 9'h010,
    ST_PUSH  = 9'h020,
    ST_ACK   = 9'h040,
    ST_END   = 9'h080,
    ST_ABORT = 9'h100
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PARITY  = 2'd1;
  localparam logic [1:0] ERR_FRAMING = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Any state register value that is not one-hot must be steered back to IDLE.
  function automatic logic is_onehot(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/fpga_receiver_fifo.sv
// First-word-fall-through word FIFO with wrap-bit pointers; head reads as zero while empty.
module fpga_receiver_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  push_take;
  logic                  pop_take;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // A push against a full FIFO is refused even if a pop frees a slot this cycle.
  assign push_take = push && !full;
  assign pop_take  = pop && !empty;
  assign rdata     = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_take) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_take)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_take) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fpga_receiver_frame.sv
// Receive endpoint of the serial link: synchronises the link, runs the four-phase handshake,
// assembles and parity-checks words and queues them for the local consumer.
module fpga_receiver_frame
  import fpga_link_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PARITY_EN      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  send,
  input  logic                  finish,
  input  logic                  serial_in,
  output logic                  acknowledge,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_done,
  output logic [7:0]            word_count,
  output logic                  error,
  output logic [1:0]            error_code
);

  localparam int NB = DATA_WIDTH + PARITY_EN;
  localparam int BW = $clog2(NB + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    sync1_reg;
  logic [2:0]    sync2_reg;
  logic          s_send;
  logic          s_fin;
  logic          s_bit;
  state_t        state_reg;
  state_t        state_prev_reg;
  logic [BW-1:0] bit_cnt_reg;
  logic [NB-1:0] shift_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic          ack_fin_reg;
  logic          tmo_hit;
  logic          tmo_allowed;
  logic          parity_ok;
  logic          req_low;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {send, finish, serial_in};
      sync2_reg <= sync1_reg;
    end
  end

  assign s_send = sync2_reg[2];
  assign s_fin  = sync2_reg[1];
  assign s_bit  = sync2_reg[0];

  // Dwell counter: equals the number of cycles already spent in the current state (from the 2nd cycle on).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_prev_reg <= ST_IDLE;
      tmo_cnt_reg    <= '0;
    end else begin
      state_prev_reg <= state_reg;
      if (state_reg != state_prev_reg) tmo_cnt_reg <= TW'(1);
      else if (tmo_cnt_reg != '1)      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end else if (TIMEOUT_CYCLES == 1) begin : g_tmo_one
      assign tmo_hit = 1'b1;
    end else begin : g_tmo
      assign tmo_hit = (state_reg == state_prev_reg) &&
                       (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  assign tmo_allowed = (state_reg != ST_IDLE) && (state_reg != ST_PUSH) && (state_reg != ST_ABORT);
  assign parity_ok   = (PARITY_EN == 0) || !(^shift_reg);
  assign req_low     = ack_fin_reg ? !s_fin : !s_send;
  assign fifo_push   = (state_reg == ST_PUSH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      ack_fin_reg <= 1'b0;
      acknowledge <= 1'b0;
      frame_done  <= 1'b0;
      word_count  <= '0;
      error       <= 1'b0;
      error_code  <= ERR_NONE;
    end else begin
      acknowledge <= 1'b0;
      frame_done  <= 1'b0;
      if (tmo_allowed && tmo_hit) begin
        state_reg   <= ST_ABORT;
        bit_cnt_reg <= '0;
        if (!error) begin
          error      <= 1'b1;
          error_code <= ERR_TIMEOUT;
        end
      end else if (!is_onehot(state_reg)) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (s_send) state_reg <= ST_START;
          end
          ST_START: begin
            error       <= 1'b0;
            error_code  <= ERR_NONE;
            word_count  <= '0;
            bit_cnt_reg <= '0;
            ack_fin_reg <= 1'b0;
            acknowledge <= 1'b1;
            state_reg   <= ST_ACK;
          end
          ST_WAIT: begin
            if (s_send) begin
              state_reg <= ST_SHIFT;
            end else if (s_fin) begin
              // frame_done is raised on entry so that it is high during the END cycle itself.
              ack_fin_reg <= 1'b1;
              frame_done  <= (bit_cnt_reg == '0);
              state_reg   <= ST_END;
            end
          end
          ST_SHIFT: begin
            shift_reg   <= {shift_reg[NB-2:0], s_bit};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BW'(NB - 1)) begin
              state_reg <= ST_CHECK;
            end else begin
              acknowledge <= 1'b1;
              state_reg   <= ST_ACK;
            end
          end
          ST_CHECK: begin
            bit_cnt_reg <= '0;
            if (parity_ok) begin
              state_reg <= ST_PUSH;
            end else begin
              if (!error) begin
                error      <= 1'b1;
                error_code <= ERR_PARITY;
              end
              acknowledge <= 1'b1;
              state_reg   <= ST_ACK;
            end
          end
          ST_PUSH: begin
            if (!fifo_full) begin
              if (word_count != 8'hFF) word_count <= word_count + 8'd1;
              acknowledge <= 1'b1;
              state_reg   <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (req_low) state_reg <= ack_fin_reg ? ST_IDLE : ST_WAIT;
            else         acknowledge <= 1'b1;
          end
          ST_END: begin
            if (bit_cnt_reg != '0 && !error) begin
              error      <= 1'b1;
              error_code <= ERR_FRAMING;
            end
            bit_cnt_reg <= '0;
            acknowledge <= 1'b1;
            state_reg   <= ST_ACK;
          end
          ST_ABORT: begin
            if (!s_send && !s_fin) state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  fpga_receiver_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (data_ready),
    .wdata (shift_reg[NB-1 -: DATA_WIDTH]),
    .rdata (data_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign data_valid = !fifo_empty;

endmodule

// File: tb/tb_fpga_receiver_frame.sv
// Directed bench for fpga_receiver_frame: a table of single-word frames plus hand-written
// sequences for two-word frames, timeout, backpressure and mid-frame reset.
module tb_fpga_receiver_frame;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       send = 1'b0;
  logic       finish = 1'b0;
  logic       serial_in = 1'b0;
  logic       data_ready = 1'b0;
  logic       acknowledge;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_done;
  logic [7:0] word_count;
  logic       error;
  logic [1:0] error_code;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  fpga_receiver_frame #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY_EN(1), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clock(clock), .reset(reset), .send(send), .finish(finish), .serial_in(serial_in),
    .acknowledge(acknowledge), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .frame_done(frame_done), .word_count(word_count),
    .error(error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         nbits;
    logic [1:0] exp_code;
    logic [7:0] exp_wc;
    int         exp_done;   // -1: frame_done not checked
    logic       exp_push;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input logic lvl, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (acknowledge === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic hs(input logic is_fin, input logic b);
    bit ok;
    @(negedge clock);
    serial_in = b;
    if (is_fin) finish = 1'b1;
    else        send = 1'b1;
    wait_ack(1'b1, 60, ok);
    chk("hs_ack_rise", 32'(ok), 32'd1);
    send = 1'b0;
    finish = 1'b0;
    wait_ack(1'b0, 60, ok);
    chk("hs_ack_fall", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [7:0] d, input logic p, input int nb);
    logic [8:0] bits;
    bits = {d, p};
    for (int i = 0; i < nb; i++) hs(1'b0, bits[8-i]);
  endtask

  task automatic pop_check(input logic [7:0] exp, input string nm);
    @(negedge clock);
    chk({nm, "_valid"}, 32'(data_valid), 32'd1);
    chk(nm, 32'(data_out), 32'(exp));
    data_ready = 1'b1;
    @(negedge clock);
    data_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int base;
    base = done_cnt;
    hs(1'b0, 1'b0);
    send_word(v.data, v.par, v.nbits);
    hs(1'b1, 1'b0);
    repeat (2) @(negedge clock);
    chk({nm, "_code"}, 32'(error_code), 32'(v.exp_code));
    chk({nm, "_err"}, 32'(error), 32'(v.exp_code != 2'd0));
    chk({nm, "_wc"}, 32'(word_count), 32'(v.exp_wc));
    if (v.exp_done >= 0) chk({nm, "_done"}, 32'(done_cnt - base), 32'(v.exp_done));
    if (v.exp_push) pop_check(v.data, {nm, "_data"});
    @(negedge clock);
    chk({nm, "_empty"}, 32'(data_valid), 32'd0);
  endtask

  vec_t       vecs[9];
  logic [7:0] bp[5];

  initial begin
    bit ok;
    bit seen;
    int hi;
    int base;

    vecs[0] = '{8'hA5, 1'b0, 9, 2'd0, 8'd1,  1, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 9, 2'd0, 8'd1,  1, 1'b1};
    vecs[2] = '{8'hA5, 1'b1, 9, 2'd1, 8'd0, -1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 9, 2'd0, 8'd1,  1, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 9, 2'd0, 8'd1,  1, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 9, 2'd1, 8'd0, -1, 1'b0};
    vecs[6] = '{8'hC3, 1'b0, 5, 2'd2, 8'd0,  0, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 0, 2'd0, 8'd0,  1, 1'b0};
    vecs[8] = '{8'h5A, 1'b0, 8, 2'd2, 8'd0,  0, 1'b0};
    bp = '{8'h11, 8'h22, 8'h44, 8'h81, 8'hF0};

    // Reset state
    #2;
    chk("rst_ack", 32'(acknowledge), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_code", 32'(error_code), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    for (int v = 0; v < 9; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Two-word clean frame
    base = done_cnt;
    hs(1'b0, 1'b0);
    send_word(8'hA5, 1'b0, 9);
    send_word(8'h3C, 1'b0, 9);
    hs(1'b1, 1'b0);
    chk("two_wc", 32'(word_count), 32'd2);
    chk("two_done", 32'(done_cnt - base), 32'd1);
    chk("two_err", 32'(error), 32'd0);
    pop_check(8'hA5, "two_w0");
    pop_check(8'h3C, "two_w1");

    // First word has a bad parity bit
    hs(1'b0, 1'b0);
    send_word(8'hA5, 1'b1, 9);
    send_word(8'h3C, 1'b0, 9);
    hs(1'b1, 1'b0);
    chk("par_err", 32'(error), 32'd1);
    chk("par_code", 32'(error_code), 32'd1);
    chk("par_wc", 32'(word_count), 32'd1);
    pop_check(8'h3C, "par_w");
    @(negedge clock);
    chk("par_empty", 32'(data_valid), 32'd0);

    // Parity error then framing error: first code sticks
    hs(1'b0, 1'b0);
    send_word(8'hA5, 1'b1, 9);
    send_word(8'hFF, 1'b0, 5);
    hs(1'b1, 1'b0);
    chk("multi_code", 32'(error_code), 32'd1);
    chk("multi_err", 32'(error), 32'd1);

    // Timeout: send held high, acknowledge dropped after 1024 cycles in ACK
    @(negedge clock);
    serial_in = 1'b0;
    send = 1'b1;
    wait_ack(1'b1, 60, ok);
    chk("tmo_ack_rise", 32'(ok), 32'd1);
    hi = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (acknowledge !== 1'b1) break;
      hi++;
    end
    chk("tmo_ack_cycles", 32'(hi), 32'd1024);
    chk("tmo_code", 32'(error_code), 32'd3);
    chk("tmo_err", 32'(error), 32'd1);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (acknowledge !== 1'b0) seen = 1'b1;
    end
    chk("tmo_ack_low", 32'(seen), 32'd0);
    send = 1'b0;
    repeat (5) @(negedge clock);
    run_vec(vecs[0], "tmo_recover");

    // Backpressure: 5th word is held until the consumer pops one
    hs(1'b0, 1'b0);
    for (int w = 0; w < 4; w++) send_word(bp[w], ^bp[w], 9);
    send_word(bp[4], 1'b0, 8);
    @(negedge clock);
    serial_in = ^bp[4];
    send = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (acknowledge !== 1'b0) seen = 1'b1;
    end
    chk("bp_ack_withheld", 32'(seen), 32'd0);
    chk("bp_wc_before", 32'(word_count), 32'd4);
    pop_check(bp[0], "bp_w0");
    wait_ack(1'b1, 60, ok);
    chk("bp_ack_after_pop", 32'(ok), 32'd1);
    send = 1'b0;
    wait_ack(1'b0, 60, ok);
    chk("bp_ack_fall", 32'(ok), 32'd1);
    hs(1'b1, 1'b0);
    chk("bp_wc", 32'(word_count), 32'd5);
    for (int w = 1; w < 5; w++) pop_check(bp[w], $sformatf("bp_w%0d", w));
    @(negedge clock);
    chk("bp_empty", 32'(data_valid), 32'd0);

    // Reset mid-word while the FIFO holds two words
    hs(1'b0, 1'b0);
    send_word(8'h12, 1'b0, 9);
    send_word(8'h34, 1'b1, 9);
    hs(1'b1, 1'b0);
    hs(1'b0, 1'b0);
    send_word(8'hE0, 1'b0, 3);
    @(negedge clock);
    serial_in = 1'b1;
    send = 1'b1;
    wait_ack(1'b1, 60, ok);
    chk("mid_ack_high", 32'(ok), 32'd1);
    chk("mid_valid_before", 32'(data_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(acknowledge), 32'd0);
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    chk("mid_rst_err", 32'(error), 32'd0);
    chk("mid_rst_code", 32'(error_code), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    send = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    hs(1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 9);
    hs(1'b1, 1'b0);
    chk("post_rst_wc", 32'(word_count), 32'd1);
    pop_check(8'h5A, "post_rst_w");
    @(negedge clock);
    chk("post_rst_empty", 32'(data_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
